// File: rtl/bram_copy_ctrl.sv
// bram_copy_ctrl: block copy sequencer for a single-port BRAM.
// Alternates read/write on the one port, ascending word order.
module bram_copy_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RAM_SIZE   = 1024,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [LEN_WIDTH-1:0]  copied,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  typedef enum logic [2:0] {
    IDLE, CHECK, RD, WR, FIN
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [LEN_WIDTH-1:0]  cnt_d;
  logic [ADDR_WIDTH:0]   src_end_d;
  logic [ADDR_WIDTH:0]   dst_end_d;
  logic [ADDR_WIDTH:0]   lim_d;
  logic                  oor_d;

  // Range check on one extra bit so huge addresses cannot wrap past it
  always_comb begin
    cnt_d     = cnt_q + LEN_WIDTH'(1);
    lim_d     = (ADDR_WIDTH+1)'(RAM_SIZE);
    src_end_d = {1'b0, src_q} + (ADDR_WIDTH+1)'(len_q);
    dst_end_d = {1'b0, dst_q} + (ADDR_WIDTH+1)'(len_q);
    oor_d     = (src_end_d > lim_d) || (dst_end_d > lim_d);
  end

  // Sequencer with registered port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            len_q   <= len;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (oor_d) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= FIN;
          end else if (len_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            addr_q  <= src_q;
            state_q <= RD;
          end
        end
        RD: begin
          we_q    <= 1'b1;
          addr_q  <= dst_q + ADDR_WIDTH'(cnt_q);
          state_q <= WR;
        end
        WR: begin
          we_q  <= 1'b0;
          cnt_q <= cnt_d;
          if (cnt_d == len_q) begin
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            addr_q  <= src_q + ADDR_WIDTH'(cnt_d);
            state_q <= RD;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write data is the read data returned this cycle, no capture stage
  assign bram_din  = (state_q == WR) ? bram_dout : '0;
  assign bram_we   = we_q;
  assign bram_addr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign copied    = cnt_q;

  // The port may only write during WR
  a_we_only_wr: assert property (
    @(posedge clk) disable iff (!rst_n)
    bram_we |-> (state_q == WR)
  );

endmodule

// File: tb/tb_bram_copy_ctrl.sv
// tb_bram_copy_ctrl: BRAM model plus behavioural copy reference.
// Directed cases, mid-copy reset and randomized commands.
module tb_bram_copy_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [10:0] len = '0;
  logic        busy, done, err;
  logic [10:0] copied;
  logic        bram_we;
  logic [31:0] bram_addr, bram_din, bram_dout;

  always #5 clk = ~clk;

  bram_copy_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err), .copied(copied),
    .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // BRAM: 1-cycle registered read, write-through output
  logic [31:0] ram [1024];
  logic [31:0] dout = '0;
  always @(posedge clk) begin
    if (bram_we) begin
      ram[bram_addr[9:0]] <= bram_din;
      dout <= bram_din;
    end else begin
      dout <= ram[bram_addr[9:0]];
    end
  end
  assign bram_dout = dout;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // Reference: expected memory image and command schedule
  logic [31:0] mem_m [1024];
  bit     act = 0;
  bit     rej = 0;
  int     t = 0;
  int     dl = 0;
  int     ml = 0;
  int     hold = 0;
  longint ms = 0;
  longint md = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      act  = 0;
      hold = 0;
    end else if (act) begin
      if (t == dl) begin
        act  = 0;
        hold = rej ? 0 : ml;
      end else begin
        t++;
      end
    end else if (start) begin
      act = 1;
      t   = 1;
      ms  = longint'(src_addr);
      md  = longint'(dst_addr);
      ml  = int'(len);
      rej = (ms + ml > 1024) || (md + ml > 1024);
      dl  = (rej || ml == 0) ? 2 : 2 + 2 * ml;
    end
  end

  task automatic cmp_cycle();
    bit rd, wr;
    int i;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_copied", copied, 0);
      chk("rst_we", bram_we, 0);
      chk("rst_addr", bram_addr, 0);
      chk("rst_din", bram_din, 0);
      return;
    end
    rd = 0;
    wr = 0;
    i  = 0;
    if (act && !rej && t >= 2 && t < dl) begin
      i  = (t - 2) / 2;
      rd = (t % 2 == 0);
      wr = !rd;
    end
    chk("busy", busy, act && t < dl);
    chk("done", done, act && t == dl);
    chk("err", err, act && t == dl && rej);
    chk("copied", copied, act ? (t < 2 ? 0 : (t - 2) / 2) : hold);
    chk("we", bram_we, wr);
    if (rd) chk("rd_addr", bram_addr, ms + i);
    if (wr) begin
      chk("wr_addr", bram_addr, md + i);
      chk("wr_din", bram_din, mem_m[int'(ms + i)]);
      mem_m[int'(md + i)] = mem_m[int'(ms + i)];
    end
  endtask

  always @(negedge clk) cmp_cycle();

  task automatic preload(input bit rnd);
    logic [31:0] v;
    for (int a = 0; a < 1024; a++) begin
      v = rnd ? $urandom : 32'(a + 'h100);
      ram[a] <= v;
      mem_m[a] = v;
    end
    #1;
  endtask

  task automatic poke(input int a, input logic [31:0] v);
    ram[a] <= v;
    mem_m[a] = v;
  endtask

  task automatic image_chk(string nm);
    int bad;
    bad = -1;
    for (int a = 0; a < 1024; a++)
      if (ram[a] !== mem_m[a] && bad < 0) bad = a;
    chk(nm, bad, -1);
  endtask

  task automatic run_cmd(input logic [31:0] s, input logic [31:0] d,
                         input int l, input bit junk,
                         output int lat, output bit e);
    bit rj;
    @(posedge clk);
    #1;
    src_addr = s;
    dst_addr = d;
    len      = 11'(l);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    src_addr = $urandom;
    dst_addr = $urandom;
    len      = 11'($urandom);
    lat = 0;
    e   = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (junk && lat == 3 && l >= 2) start = 1'b1;
      if (lat == 4) start = 1'b0;
      if (done === 1'b1) begin
        e = err;
        break;
      end
      if (lat > 3000) begin
        chk("done_timeout", 0, 1);
        break;
      end
    end
    rj = (longint'(s) + l > 1024) || (longint'(d) + l > 1024);
    chk("latency", lat, (rj || l == 0) ? 2 : 2 + 2 * l);
    chk("err_at_done", e, rj);
    image_chk("ram_image");
  endtask

  int lat;
  bit e;

  initial begin
    int l, mode;
    logic [31:0] s, d;

    repeat (3) @(negedge clk);
    preload(0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_copied", copied, 0);

    // basic 4-word copy
    run_cmd(0, 512, 4, 0, lat, e);
    chk("t1_lat", lat, 10);
    chk("t1_err", e, 0);
    for (int j = 0; j < 4; j++) begin
      chk("t1_dst", ram[512 + j], 'h100 + j);
      chk("t1_src", ram[j], 'h100 + j);
    end
    @(negedge clk);
    chk("t1_copied_hold", copied, 4);

    // zero length
    run_cmd(5, 6, 0, 0, lat, e);
    chk("t2_lat", lat, 2);
    chk("t2_copied", copied, 0);
    chk("t2_ram6", ram[6], 'h106);

    // rejected: source end 1028
    run_cmd(1020, 0, 8, 0, lat, e);
    chk("t3_lat", lat, 2);
    chk("t3_err", e, 1);
    chk("t3_ram0", ram[0], 'h100);

    // accepted: destination end exactly 1024
    run_cmd(0, 1016, 8, 0, lat, e);
    chk("t4_lat", lat, 18);
    chk("t4_err", e, 0);
    chk("t4_last", ram[1023], 'h107);

    // overlapping forward copy replicates the first word
    @(negedge clk);
    poke(10, 32'hAAAA_0001);
    poke(11, 32'hBBBB_0002);
    poke(12, 32'hCCCC_0003);
    poke(13, 32'hDDDD_0004);
    run_cmd(10, 11, 3, 0, lat, e);
    for (int j = 10; j < 14; j++)
      chk("t5_overlap", ram[j], 32'hAAAA_0001);

    // start pulsed again mid-copy
    run_cmd(200, 600, 6, 1, lat, e);
    chk("t6_lat", lat, 14);
    chk("t6_word", ram[605], 'h100 + 205);

    // reset during WR of word 2 of an 8-word copy
    @(posedge clk);
    #1;
    src_addr = 100;
    dst_addr = 300;
    len      = 8;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_we", bram_we, 0);
    chk("t7_addr", bram_addr, 0);
    chk("t7_copied", copied, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("t7_w0", ram[300], 'h164);
    chk("t7_w1", ram[301], 'h165);
    chk("t7_w2", ram[302], 'h100 + 302);
    image_chk("t7_image");
    run_cmd(100, 300, 8, 0, lat, e);
    chk("t7_fresh", ram[307], 'h16B);

    // randomized commands
    preload(1);
    for (int n = 0; n < 40; n++) begin
      mode = $urandom_range(0, 4);
      l    = $urandom_range(0, 24);
      s    = $urandom_range(0, 1024 - l);
      d    = $urandom_range(0, 1024 - l);
      if (mode == 0) begin
        l = $urandom_range(2, 24);
        s = $urandom_range(1025 - l, 1023);
        d = $urandom_range(0, 1000);
      end else if (mode == 1) begin
        l = $urandom_range(1, 24);
        s = 32'hFFFF_FF00 + $urandom_range(0, 255);
      end else if (mode == 2) begin
        s = $urandom_range(0, 1020 - l);
        d = s + $urandom_range(0, 3);
        if ($urandom_range(0, 1) == 1) begin
          logic [31:0] tmp;
          tmp = s;
          s = d;
          d = tmp;
        end
      end
      run_cmd(s, d, l, 1'($urandom_range(0, 1)), lat, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
